fir_coef_scheduler: RTL and testbench
=====================================

FIR_COEF_SCHEDULER -- requirements
Module: fir_coef_scheduler

Interface
REQ-001 SHALL have parameter DATA_BUS_SIZE, default 11: coefficient word width, two's complement.
REQ-002 SHALL have parameter TAPS, default 3: number of complex FIR taps served.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sample_valid, input, 1: one-cycle strobe per new input sample.
REQ-006 SHALL have port sig_enable, output, 1: FIR delay-line enable.
REQ-007 SHALL have port coef_valid, input, 1: coefficient write request.
REQ-008 SHALL have port coef_ready, output, 1: write may be accepted.
REQ-009 SHALL have port coef_index, input, $clog2(TAPS) (min 1): tap number of the write.
REQ-010 SHALL have ports coef_I and coef_Q, input, DATA_BUS_SIZE each, signed: write data.
REQ-011 SHALL have port coef_last, input, 1: marks the final write of a coefficient set.
REQ-012 SHALL have port coef_abort, input, 1: discards the set being loaded.
REQ-013 SHALL have ports fir_coef_I[TAPS] and fir_coef_Q[TAPS], output, DATA_BUS_SIZE each, signed: active coefficients driven to the FIR.
REQ-014 SHALL have port commit_pending, output, 1: a complete set is waiting for a sample boundary.
REQ-015 SHALL have port index_error, output, 1: sticky; an accepted write had coef_index >= TAPS.

Function
REQ-016 SHALL hold two banks: shadow (write target) and active (drives fir_coef_*).
REQ-017 SHALL implement states IDLE, LOAD and PENDING.
REQ-018 SHALL accept a write on the edge where coef_valid & coef_ready, storing coef_I/coef_Q into shadow[coef_index].
REQ-019 SHALL drive coef_ready high in IDLE and LOAD, low in PENDING.
REQ-020 SHALL move to LOAD on an accepted write with coef_last=0, and to PENDING on an accepted write with coef_last=1, from either IDLE or LOAD.
REQ-021 SHALL, in PENDING on the edge where sample_valid=1, copy the whole shadow bank to active in one cycle and return to IDLE.
REQ-022 SHALL register sig_enable from sample_valid with exactly 1-cycle latency in every state, so the first sample after a swap is filtered with the complete new set.
REQ-023 SHALL drive commit_pending = (state == PENDING).
REQ-024 SHALL, when coef_abort=1 in LOAD or PENDING, restore shadow from active and enter IDLE; abort beats a same-cycle swap and a same-cycle write.
REQ-025 SHALL treat coef_abort in IDLE as a no-op.
REQ-026 SHALL drop the data of an accepted write with coef_index >= TAPS, still apply its coef_last state transition, and set index_error.
REQ-027 SHALL, when an accepted coef_last write and sample_valid fall in the same cycle, store the write, enter PENDING and perform no swap until the next sample_valid.
REQ-028 SHALL leave shadow taps not written since the last swap or abort holding their current active values.
REQ-029 SHALL never modify active except by a swap (REQ-021) or reset.

Reset
REQ-030 SHALL, on reset low, asynchronously clear both banks to zero, set state IDLE, and drive sig_enable=0, commit_pending=0 and index_error=0.
REQ-031 SHALL drive coef_ready=1 from the first clock after reset deasserts; reset mid-load or mid-PENDING discards the set.

Configuration
REQ-032 SHALL, with macro FIR_COEF_SCHED_STATS_EN defined, add output swap_count (16-bit, +1 per swap, wraps) and output abort_count (8-bit, +1 per effective abort, saturates at 255), both reset to 0.
REQ-033 SHALL, without FIR_COEF_SCHED_STATS_EN, omit both ports and their counters; all other behaviour is unchanged.

Structure
REQ-034 SHALL take the state enum, the STATS_COUNT_W=16 and ABORT_COUNT_W=8 constants, and a coefficient-word typedef from shared package fir_sched_pkg.
REQ-035 SHALL place both banks with their copy (swap) and restore (abort) operations in sub-module fir_coef_bank; the FSM and handshake stay in fir_coef_scheduler.

Verification
REQ-036 SHALL cover: reset, then write taps 0,1,2 = (1,0),(2,-1),(-3,4) with last on tap 2, then sample_valid -> fir_coef unchanged until the swap edge, new values after it, sig_enable high exactly one cycle after sample_valid.
REQ-037 SHALL cover: in PENDING, drive coef_valid=1 -> coef_ready=0, shadow untouched, commit_pending=1 until the next sample_valid.
REQ-038 SHALL cover: load taps 0,1, then coef_abort together with sample_valid -> active unchanged, state IDLE, abort_count=1 when STATS enabled.
REQ-039 SHALL cover: write coef_index=3 with TAPS=3 and coef_last=1 -> index_error=1, no bank change, PENDING entered.
REQ-040 SHALL cover: coef_last write in the same cycle as sample_valid -> no swap that cycle; swap on the next sample_valid.
REQ-041 SHALL cover: reset asserted while PENDING -> all outputs zero immediately, swap_count=0.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR coefficient scheduler.
package fir_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_PENDING = 2'd2
   } sched_state_e;

   localparam int STATS_COUNT_W = 16;
   localparam int ABORT_COUNT_W = 8;
   localparam int COEF_W        = 11;

   typedef logic signed [COEF_W-1:0] coef_t;

   function automatic int idx_width(input int taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks: shadow takes writes, swap copies shadow to
// active, restore copies active back to shadow. Restore wins over swap and write.
module fir_coef_bank
   import fir_sched_pkg::*;
#(
   parameter int W     = 11,
   parameter int TAPS  = 3,
   parameter int IDX_W = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic signed [W-1:0] wr_I,
   input  logic signed [W-1:0] wr_Q,
   input  logic                swap,
   input  logic                restore,
   output logic signed [W-1:0] act_I [TAPS],
   output logic signed [W-1:0] act_Q [TAPS]
);

   logic signed [W-1:0] shadow_I_q [TAPS];
   logic signed [W-1:0] shadow_Q_q [TAPS];
   logic signed [W-1:0] active_I_q [TAPS];
   logic signed [W-1:0] active_Q_q [TAPS];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < TAPS; k++) begin
            shadow_I_q[k] <= '0;
            shadow_Q_q[k] <= '0;
            active_I_q[k] <= '0;
            active_Q_q[k] <= '0;
         end
      end else if (restore) begin
         for (int k = 0; k < TAPS; k++) begin
            shadow_I_q[k] <= active_I_q[k];
            shadow_Q_q[k] <= active_Q_q[k];
         end
      end else begin
         if (swap) begin
            for (int k = 0; k < TAPS; k++) begin
               active_I_q[k] <= shadow_I_q[k];
               active_Q_q[k] <= shadow_Q_q[k];
            end
         end
         // wr_en is only raised for in-range indices
         if (wr_en) begin
            shadow_I_q[wr_idx] <= wr_I;
            shadow_Q_q[wr_idx] <= wr_Q;
         end
      end
   end

   assign act_I = active_I_q;
   assign act_Q = active_Q_q;

endmodule

// File: rtl/fir_coef_scheduler.sv
// Double-buffered FIR coefficient loader that commits a full set on a sample
// boundary. Optional statistics counters under macro FIR_COEF_SCHED_STATS_EN.
//
// state     | meaning
// S_IDLE    | no set in progress, writes accepted
// S_LOAD    | partial set in shadow, writes accepted
// S_PENDING | complete set waiting for sample_valid, writes blocked
module fir_coef_scheduler
   import fir_sched_pkg::*;
#(
   parameter  int DATA_BUS_SIZE = 11,
   parameter  int TAPS          = 3,
   localparam int IDX_W         = idx_width(TAPS)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            sample_valid,
   output logic                            sig_enable,
   input  logic                            coef_valid,
   output logic                            coef_ready,
   input  logic [IDX_W-1:0]                coef_index,
   input  logic signed [DATA_BUS_SIZE-1:0] coef_I,
   input  logic signed [DATA_BUS_SIZE-1:0] coef_Q,
   input  logic                            coef_last,
   input  logic                            coef_abort,
   output logic signed [DATA_BUS_SIZE-1:0] fir_coef_I [TAPS],
   output logic signed [DATA_BUS_SIZE-1:0] fir_coef_Q [TAPS],
   output logic                            commit_pending,
   output logic                            index_error
`ifdef FIR_COEF_SCHED_STATS_EN
  ,output logic [STATS_COUNT_W-1:0]        swap_count,
   output logic [ABORT_COUNT_W-1:0]        abort_count
`endif
);

   sched_state_e state_q, state_d;
   logic         ready_q, pending_q, sig_enable_q, index_error_q, index_error_d;
   logic         accept, abort_eff, idx_ok, wr_en, swap, restore;

   always_comb begin
      abort_eff     = coef_abort && (state_q != S_IDLE);
      accept        = coef_valid && ready_q;
      idx_ok        = int'(coef_index) < TAPS;
      state_d       = state_q;
      wr_en         = 1'b0;
      swap          = 1'b0;
      restore       = 1'b0;
      index_error_d = index_error_q;
      if (abort_eff) begin
         state_d = S_IDLE;
         restore = 1'b1;
      end else begin
         case (state_q)
            S_IDLE, S_LOAD: begin
               if (accept) begin
                  state_d = coef_last ? S_PENDING : S_LOAD;
                  wr_en   = idx_ok;
                  if (!idx_ok) index_error_d = 1'b1;
               end
            end
            S_PENDING: begin
               if (sample_valid) begin
                  swap    = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         ready_q       <= 1'b0;
         pending_q     <= 1'b0;
         sig_enable_q  <= 1'b0;
         index_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_q       <= (state_d != S_PENDING);
         pending_q     <= (state_d == S_PENDING);
         sig_enable_q  <= sample_valid;
         index_error_q <= index_error_d;
      end
   end

   assign coef_ready     = ready_q;
   assign commit_pending = pending_q;
   assign sig_enable     = sig_enable_q;
   assign index_error    = index_error_q;

`ifdef FIR_COEF_SCHED_STATS_EN
   logic [STATS_COUNT_W-1:0] swap_count_q;
   logic [ABORT_COUNT_W-1:0] abort_count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         swap_count_q  <= '0;
         abort_count_q <= '0;
      end else begin
         if (swap) swap_count_q <= swap_count_q + 1'b1;
         if (abort_eff && (abort_count_q != '1)) abort_count_q <= abort_count_q + 1'b1;
      end
   end

   assign swap_count  = swap_count_q;
   assign abort_count = abort_count_q;
`endif

   fir_coef_bank #(
      .W     (DATA_BUS_SIZE),
      .TAPS  (TAPS),
      .IDX_W (IDX_W)
   ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_idx  (coef_index),
      .wr_I    (coef_I),
      .wr_Q    (coef_Q),
      .swap    (swap),
      .restore (restore),
      .act_I   (fir_coef_I),
      .act_Q   (fir_coef_Q)
   );

endmodule

// File: tb/tb_fir_coef_scheduler.sv
// Scoreboard bench for fir_coef_scheduler: each sample pushes the expected
// active set, a negedge monitor checks it when sig_enable rises.
module tb_fir_coef_scheduler;
   import fir_sched_pkg::*;

   localparam int W    = 11;
   localparam int TAPS = 3;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                sample_valid = 1'b0;
   logic                coef_valid = 1'b0;
   logic [1:0]          coef_index = '0;
   logic signed [W-1:0] coef_I = '0;
   logic signed [W-1:0] coef_Q = '0;
   logic                coef_last = 1'b0;
   logic                coef_abort = 1'b0;
   logic                sig_enable, coef_ready, commit_pending, index_error;
   logic signed [W-1:0] fir_coef_I [TAPS];
   logic signed [W-1:0] fir_coef_Q [TAPS];
`ifdef FIR_COEF_SCHED_STATS_EN
   logic [STATS_COUNT_W-1:0] swap_count;
   logic [ABORT_COUNT_W-1:0] abort_count;
`endif

   fir_coef_scheduler #(.DATA_BUS_SIZE(W), .TAPS(TAPS)) dut (
      .clock          (clock),
      .reset          (reset),
      .sample_valid   (sample_valid),
      .sig_enable     (sig_enable),
      .coef_valid     (coef_valid),
      .coef_ready     (coef_ready),
      .coef_index     (coef_index),
      .coef_I         (coef_I),
      .coef_Q         (coef_Q),
      .coef_last      (coef_last),
      .coef_abort     (coef_abort),
      .fir_coef_I     (fir_coef_I),
      .fir_coef_Q     (fir_coef_Q),
      .commit_pending (commit_pending),
      .index_error    (index_error)
`ifdef FIR_COEF_SCHED_STATS_EN
     ,.swap_count     (swap_count),
      .abort_count    (abort_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      coef_t i [TAPS];
      coef_t q [TAPS];
      logic  pend;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_active(input string name, input int i0, input int i1, input int i2,
                             input int q0, input int q1, input int q2);
      int ei [TAPS];
      int eq [TAPS];
      ei = '{i0, i1, i2};
      eq = '{q0, q1, q2};
      for (int k = 0; k < TAPS; k++) begin
         chk($sformatf("%s_I[%0d]", name, k), fir_coef_I[k], ei[k]);
         chk($sformatf("%s_Q[%0d]", name, k), fir_coef_Q[k], eq[k]);
      end
   endtask

   task automatic push_exp(input int i0, input int i1, input int i2,
                           input int q0, input int q1, input int q2, input logic pend);
      exp_t e;
      e.i[0] = coef_t'(i0); e.i[1] = coef_t'(i1); e.i[2] = coef_t'(i2);
      e.q[0] = coef_t'(q0); e.q[1] = coef_t'(q1); e.q[2] = coef_t'(q2);
      e.pend = pend;
      sb.push_back(e);
   endtask

   always @(negedge clock) begin
      if (reset && sig_enable) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_sig_enable: got 1 expected 0 (no sample pending)");
         end else begin
            mon_e = sb.pop_front();
            for (int k = 0; k < TAPS; k++) begin
               chk($sformatf("mon_coef_I[%0d]", k), fir_coef_I[k], mon_e.i[k]);
               chk($sformatf("mon_coef_Q[%0d]", k), fir_coef_Q[k], mon_e.q[k]);
            end
            chk("mon_commit_pending", commit_pending, mon_e.pend);
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int idx, input int ci, input int cq, input logic last);
      coef_valid = 1'b1;
      coef_index = idx[1:0];
      coef_I     = coef_t'(ci);
      coef_Q     = coef_t'(cq);
      coef_last  = last;
      cyc();
      coef_valid = 1'b0;
      coef_last  = 1'b0;
   endtask

   task automatic sample(input int i0, input int i1, input int i2,
                         input int q0, input int q1, input int q2, input logic pend);
      sample_valid = 1'b1;
      push_exp(i0, i1, i2, q0, q1, q2, pend);
      cyc();
      sample_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk_active("rst", 0, 0, 0, 0, 0, 0);
      chk("rst_sig_enable", sig_enable, 0);
      chk("rst_commit_pending", commit_pending, 0);
      chk("rst_index_error", index_error, 0);
      reset = 1'b1;
      cyc();
      chk("rst_coef_ready", coef_ready, 1);

      // basic load and swap
      wr(0, 1, 0, 1'b0);
      chk("t1_pending_load", commit_pending, 0);
      chk("t1_ready_load", coef_ready, 1);
      wr(1, 2, -1, 1'b0);
      wr(2, -3, 4, 1'b1);
      chk("t1_pending", commit_pending, 1);
      chk("t1_ready_pending", coef_ready, 0);
      chk_active("t1_before", 0, 0, 0, 0, 0, 0);
      cyc();
      chk_active("t1_before2", 0, 0, 0, 0, 0, 0);
      sample(1, 2, -3, 0, -1, 4, 1'b0);
      chk("t1_sig_enable", sig_enable, 1);
      chk_active("t1_after", 1, 2, -3, 0, -1, 4);
      chk("t1_pending_after", commit_pending, 0);
      cyc();
      chk("t1_sig_enable_drop", sig_enable, 0);

      // writes blocked in PENDING
      wr(0, 5, 5, 1'b1);
      chk("t2_pending", commit_pending, 1);
      coef_valid = 1'b1;
      coef_index = 2'd1;
      coef_I     = 11'sd7;
      coef_Q     = 11'sd7;
      for (int n = 0; n < 2; n++) begin
         cyc();
         chk("t2_ready_blocked", coef_ready, 0);
         chk("t2_pending_hold", commit_pending, 1);
      end
      coef_valid = 1'b0;
      sample(5, 2, -3, 5, -1, 4, 1'b0);
      chk_active("t2_after", 5, 2, -3, 5, -1, 4);

      // abort beats sample; shadow restored
      wr(0, 9, 9, 1'b0);
      wr(1, 8, 8, 1'b0);
      coef_abort = 1'b1;
      sample(5, 2, -3, 5, -1, 4, 1'b0);
      coef_abort = 1'b0;
      chk("t3_pending", commit_pending, 0);
      chk("t3_ready", coef_ready, 1);
      chk_active("t3_after_abort", 5, 2, -3, 5, -1, 4);
`ifdef FIR_COEF_SCHED_STATS_EN
      chk("t3_abort_count", abort_count, 1);
`endif
      wr(2, 6, 6, 1'b1);
      sample(5, 2, 6, 5, -1, 6, 1'b0);
      chk_active("t3_restored", 5, 2, 6, 5, -1, 6);

      // out-of-range index
      chk("t4_index_error_clear", index_error, 0);
      wr(3, 7, 7, 1'b1);
      chk("t4_index_error", index_error, 1);
      chk("t4_pending", commit_pending, 1);
      sample(5, 2, 6, 5, -1, 6, 1'b0);
      chk_active("t4_after", 5, 2, 6, 5, -1, 6);
      chk("t4_index_error_sticky", index_error, 1);

      // last write coincides with sample: swap deferred
      wr(0, -1, -2, 1'b0);
      wr(2, -1024, 1023, 1'b0);
      coef_valid = 1'b1;
      coef_index = 2'd1;
      coef_I     = -11'sd4;
      coef_Q     = 11'sd3;
      coef_last  = 1'b1;
      sample(5, 2, 6, 5, -1, 6, 1'b1);
      coef_valid = 1'b0;
      coef_last  = 1'b0;
      chk("t5_pending", commit_pending, 1);
      chk_active("t5_no_swap", 5, 2, 6, 5, -1, 6);
      cyc();
      sample(-1, -4, -1024, -2, 3, 1023, 1'b0);
      chk_active("t5_swap", -1, -4, -1024, -2, 3, 1023);
`ifdef FIR_COEF_SCHED_STATS_EN
      chk("t5_swap_count", swap_count, 5);
`endif

      // reset during PENDING
      wr(0, 1, 1, 1'b1);
      chk("t6_pending", commit_pending, 1);
      #2;
      reset = 1'b0;
      #1;
      chk_active("t6_rst", 0, 0, 0, 0, 0, 0);
      chk("t6_rst_pending", commit_pending, 0);
      chk("t6_rst_sig_enable", sig_enable, 0);
      chk("t6_rst_index_error", index_error, 0);
      chk("t6_rst_ready", coef_ready, 0);
`ifdef FIR_COEF_SCHED_STATS_EN
      chk("t6_rst_swap_count", swap_count, 0);
      chk("t6_rst_abort_count", abort_count, 0);
`endif
      cyc();
      reset = 1'b1;
      cyc();
      chk("t6_ready", coef_ready, 1);
      chk("t6_pending_after", commit_pending, 0);
      sample(0, 0, 0, 0, 0, 0, 1'b0);
      chk_active("t6_discarded", 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 20 && sb.size() != 0; n++) cyc();
      cyc();
      chk("scoreboard_drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
